// File: rtl/div_hs_pkg.sv
// Shared definitions for the divider Start/Ack handshake initiator.
//   DIV_W            operand/result width of the 4-bit divider
//   ERR_QUOT/ERR_REM response payload returned with rsp_err
//   state_e          3-bit handshake state encoding
package div_hs_pkg;

  localparam int unsigned DIV_W = 4;

  localparam logic [DIV_W-1:0] ERR_QUOT = 4'hF;
  localparam logic [DIV_W-1:0] ERR_REM  = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/div_hs_watchdog.sv
// Per-phase cycle watchdog for the divider handshake initiator.
// Only compiled when DIV_HS_TIMEOUT_EN is defined.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   clear_i    restart the count (phase change)
//   tick_i     count this cycle (block is in a waiting phase)
//   expired_o  high on the LIMIT-th consecutive ticked cycle of a phase
`ifdef DIV_HS_TIMEOUT_EN
module div_hs_watchdog #(
  parameter int unsigned LIMIT = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of already-elapsed cycles in the phase, so the
  // LIMIT-th cycle is the one where it reads LIMIT-1.
  assign expired_o = tick_i && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/divider_handshake_initiator.sv
// Hardware requester for the 4-bit divider Start/Ack handshake.
// Takes one (X,Y) operand pair on a valid/ready request port, drives Start
// until the divider leaves INITIAL, waits for Done, captures the result,
// drives Ack until the divider is back in INITIAL, then presents the result
// on a valid/ready response port. A zero divisor is rejected without
// touching the divider.
// Optional feature: define DIV_HS_TIMEOUT_EN to add a per-phase watchdog
// (TIMEOUT_CYCLES) that aborts START/WAIT/ACK with an error response.
// Ports:
//   Clk, Reset                       clock, synchronous active-high reset
//   req_valid/req_ready/req_x/req_y  operand request channel
//   div_x/div_y/div_start/div_ack    registered drive to divider
//   div_qi/div_done/div_quot/div_rem status/result from divider
//   rsp_valid/rsp_ready              response channel handshake
//   rsp_quot/rsp_rem/rsp_err         response payload (err: 4'hF / 4'h0)
module divider_handshake_initiator
  import div_hs_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DIV_W-1:0] req_x,
  input  logic [DIV_W-1:0] req_y,
  output logic [DIV_W-1:0] div_x,
  output logic [DIV_W-1:0] div_y,
  output logic             div_start,
  output logic             div_ack,
  input  logic             div_qi,
  input  logic             div_done,
  input  logic [DIV_W-1:0] div_quot,
  input  logic [DIV_W-1:0] div_rem,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DIV_W-1:0] rsp_quot,
  output logic [DIV_W-1:0] rsp_rem,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic [DIV_W-1:0] div_x_q, div_x_d;
  logic [DIV_W-1:0] div_y_q, div_y_d;
  logic             start_q, start_d;
  logic             ack_q, ack_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DIV_W-1:0] rsp_quot_q, rsp_quot_d;
  logic [DIV_W-1:0] rsp_rem_q, rsp_rem_d;
  logic             rsp_err_q, rsp_err_d;
  logic             timeout;

`ifdef DIV_HS_TIMEOUT_EN
  logic wd_tick;
  logic wd_clear;

  assign wd_tick  = (state_q == ST_START) || (state_q == ST_WAIT) ||
                    (state_q == ST_ACK);
  assign wd_clear = (state_d != state_q);

  div_hs_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .clear_i  (wd_clear),
    .tick_i   (wd_tick),
    .expired_o(timeout)
  );
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    div_x_d     = div_x_q;
    div_y_d     = div_y_q;
    start_d     = start_q;
    ack_d       = ack_q;
    rsp_valid_d = rsp_valid_q;
    rsp_quot_d  = rsp_quot_q;
    rsp_rem_d   = rsp_rem_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          div_x_d     = req_x;
          div_y_d     = req_y;
          if (req_y == '0) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_quot_d  = ERR_QUOT;
            rsp_rem_d   = ERR_REM;
          end else begin
            state_d   = ST_START;
            start_d   = 1'b1;
            rsp_err_d = 1'b0;
          end
        end
      end
      // A stale Done seen here is ignored; only leaving INITIAL counts.
      ST_START: begin
        if (!div_qi) begin
          state_d = ST_WAIT;
          start_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (div_done) begin
          state_d    = ST_ACK;
          ack_d      = 1'b1;
          rsp_quot_d = div_quot;
          rsp_rem_d  = div_rem;
        end
      end
      ST_ACK: begin
        if (div_qi) begin
          state_d     = ST_RESP;
          ack_d       = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        start_d     = 1'b0;
        ack_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase

    // Watchdog abort overrides whatever the phase decided this cycle.
    if (timeout) begin
      state_d     = ST_RESP;
      start_d     = 1'b0;
      ack_d       = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_quot_d  = ERR_QUOT;
      rsp_rem_d   = ERR_REM;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      div_x_q     <= '0;
      div_y_q     <= '0;
      start_q     <= 1'b0;
      ack_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_quot_q  <= '0;
      rsp_rem_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      div_x_q     <= div_x_d;
      div_y_q     <= div_y_d;
      start_q     <= start_d;
      ack_q       <= ack_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_quot_q  <= rsp_quot_d;
      rsp_rem_q   <= rsp_rem_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign div_x     = div_x_q;
  assign div_y     = div_y_q;
  assign div_start = start_q;
  assign div_ack   = ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_quot  = rsp_quot_q;
  assign rsp_rem   = rsp_rem_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_divider_handshake_initiator.sv
// Directed bench for divider_handshake_initiator with a behavioural model of
// the divider's Qi/Done handshake (configurable start, poll and ack delays).
module tb_divider_handshake_initiator;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_x, req_y;
  logic [3:0] div_x, div_y;
  logic       div_start, div_ack;
  logic       div_qi, div_done;
  logic [3:0] div_quot, div_rem;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_quot, rsp_rem;
  logic       rsp_err;

  always #5 Clk = ~Clk;

  divider_handshake_initiator #(
    .TIMEOUT_CYCLES(50)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x    (req_x),
    .req_y    (req_y),
    .div_x    (div_x),
    .div_y    (div_y),
    .div_start(div_start),
    .div_ack  (div_ack),
    .div_qi   (div_qi),
    .div_done (div_done),
    .div_quot (div_quot),
    .div_rem  (div_rem),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_quot (rsp_quot),
    .rsp_rem  (rsp_rem),
    .rsp_err  (rsp_err)
  );

  // Divider model: 0 = INITIAL, 1 = computing, 2 = DONE waiting for Ack.
  logic        m_rst;
  logic        stale_done;
  logic        never_done;
  int unsigned start_delay, poll_delay, ack_delay;
  int unsigned m_st, m_cnt;

  always @(posedge Clk) begin
    if (m_rst) begin
      m_st <= 0; m_cnt <= 0; div_qi <= 1'b1; div_done <= 1'b0;
      div_quot <= 4'h0; div_rem <= 4'h0;
    end else begin
      case (m_st)
        0: begin
          div_qi   <= 1'b1;
          div_done <= stale_done;
          if (div_start) begin
            if (m_cnt >= start_delay) begin
              m_st <= 1; m_cnt <= 0; div_qi <= 1'b0; div_done <= 1'b0;
            end else m_cnt <= m_cnt + 1;
          end else m_cnt <= 0;
        end
        1: begin
          if (!never_done && (m_cnt + 1 >= poll_delay)) begin
            m_st <= 2; m_cnt <= 0; div_done <= 1'b1;
            div_quot <= div_x / div_y;
            div_rem  <= div_x % div_y;
          end else m_cnt <= m_cnt + 1;
        end
        default: begin
          if (div_ack) begin
            if (m_cnt >= ack_delay) begin
              // Result lines go to garbage once back in INITIAL.
              m_st <= 0; m_cnt <= 0; div_qi <= 1'b1; div_done <= 1'b0;
              div_quot <= 4'hA; div_rem <= 4'hA;
            end else m_cnt <= m_cnt + 1;
          end
        end
      endcase
    end
  end

  // Handshake monitors.
  int unsigned start_hi = 0, start_rises = 0, ack_rises = 0, overlap = 0;
  logic start_prev = 1'b0, ack_prev = 1'b0;
  always @(negedge Clk) begin
    if (div_start === 1'b1) start_hi++;
    if (div_start === 1'b1 && !start_prev) start_rises++;
    if (div_ack === 1'b1 && !ack_prev) ack_rises++;
    if (div_start === 1'b1 && div_ack === 1'b1) overlap++;
    start_prev = (div_start === 1'b1);
    ack_prev   = (div_ack === 1'b1);
  end

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [3:0] x, input logic [3:0] y);
    int unsigned n = 0;
    while (req_ready !== 1'b1 && n < 200) begin cyc(1); n++; end
    chk({tag, "_req_ready"}, req_ready, 1);
    req_x = x; req_y = y; req_valid = 1'b1;
    cyc(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, output int unsigned n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin cyc(1); n++; end
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
  endtask

  task automatic pop(input string tag);
    rsp_ready = 1'b1;
    cyc(1);
    rsp_ready = 1'b0;
    chk({tag, "_pop_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_pop_req_ready"}, req_ready, 1);
  endtask

  int unsigned lat, b_hi, b_sr, b_ar, b_ov;

  initial begin
    Reset = 1'b1; m_rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_x = 4'h0; req_y = 4'h0;
    stale_done = 1'b0; never_done = 1'b0;
    start_delay = 0; poll_delay = 20; ack_delay = 0;
    cyc(3);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_start", div_start, 0);
    chk("rst_ack", div_ack, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_div_xy", {div_x, div_y}, 8'h00);
    chk("rst_rsp_data", {rsp_quot, rsp_rem}, 8'h00);
    Reset = 1'b0; m_rst = 1'b0;
    cyc(1);

    // 1: 13/4 with Done 20 cycles after start; latency = start+poll+4.
    b_hi = start_hi; b_sr = start_rises; b_ar = ack_rises; b_ov = overlap;
    send("t1", 4'd13, 4'd4);
    chk("t1_start_on_accept", div_start, 1);
    chk("t1_div_xy", {div_x, div_y}, 8'hD4);
    wait_rsp("t1", lat);
    chk("t1_latency", lat, 24);
    chk("t1_quot", rsp_quot, 3);
    chk("t1_rem", rsp_rem, 1);
    chk("t1_err", rsp_err, 0);
    chk("t1_start_rises", start_rises - b_sr, 1);
    chk("t1_start_hi_cycles", start_hi - b_hi, 2);
    chk("t1_ack_rises", ack_rises - b_ar, 1);
    chk("t1_overlap", overlap - b_ov, 0);
    chk("t1_div_xy_in_resp", {div_x, div_y}, 8'hD4);
    pop("t1");

    // 2: zero divisor rejected one cycle after accept, Start never raised.
    b_sr = start_rises;
    send("t2", 4'd5, 4'd0);
    chk("t2_rsp_valid_1cyc", rsp_valid, 1);
    chk("t2_err", rsp_err, 1);
    chk("t2_quot", rsp_quot, 4'hF);
    chk("t2_rem", rsp_rem, 4'h0);
    chk("t2_start", div_start, 0);
    chk("t2_start_rises", start_rises - b_sr, 0);
    pop("t2");

    // 3: back-to-back, second request held while response stalls.
    poll_delay = 3;
    send("t3a", 4'd15, 4'd1);
    req_x = 4'd2; req_y = 4'd7; req_valid = 1'b1;
    wait_rsp("t3a", lat);
    chk("t3a_latency", lat, 7);
    for (int unsigned i = 0; i < 5; i++) begin
      cyc(1);
      chk("t3a_stall_valid", rsp_valid, 1);
      chk("t3a_stall_data", {rsp_quot, rsp_rem, rsp_err}, 9'h1E0);
    end
    chk("t3a_stall_req_ready", req_ready, 0);
    chk("t3a_stall_div_x", div_x, 15);
    rsp_ready = 1'b1;
    cyc(1);
    rsp_ready = 1'b0;
    chk("t3_idle_rsp_valid", rsp_valid, 0);
    chk("t3_idle_req_ready", req_ready, 1);
    chk("t3_not_yet_started", div_start, 0);
    cyc(1);
    req_valid = 1'b0;
    chk("t3b_start", div_start, 1);
    chk("t3b_div_xy", {div_x, div_y}, 8'h27);
    wait_rsp("t3b", lat);
    chk("t3b_latency", lat, 7);
    chk("t3b_data", {rsp_quot, rsp_rem, rsp_err}, 9'h004);
    pop("t3b");

    // 6: stale Done at START entry, divider leaves INITIAL one edge late.
    stale_done = 1'b1; start_delay = 1; poll_delay = 4;
    cyc(2);
    b_hi = start_hi;
    send("t6", 4'd11, 4'd3);
    wait_rsp("t6", lat);
    chk("t6_start_hi_cycles", start_hi - b_hi, 3);
    chk("t6_latency", lat, 9);
    chk("t6_data", {rsp_quot, rsp_rem, rsp_err}, 9'h064);
    stale_done = 1'b0; start_delay = 0;
    pop("t6");

    // 4: reset while Ack is held.
    poll_delay = 2; ack_delay = 10;
    send("t4", 4'd9, 4'd3);
    lat = 0;
    while (div_ack !== 1'b1 && lat < 200) begin cyc(1); lat++; end
    chk("t4_ack_seen", div_ack, 1);
    Reset = 1'b1;
    cyc(1);
    chk("t4_ack_dropped", div_ack, 0);
    chk("t4_req_ready", req_ready, 1);
    chk("t4_rsp_valid", rsp_valid, 0);
    chk("t4_start", div_start, 0);
    Reset = 1'b0; m_rst = 1'b1;
    cyc(1);
    m_rst = 1'b0; ack_delay = 0;
    cyc(1);

`ifdef DIV_HS_TIMEOUT_EN
    // 5: divider never finishes; 50 cycles in WAIT then error response.
    never_done = 1'b1;
    send("t5", 4'd7, 4'd2);
    wait_rsp("t5", lat);
    chk("t5_latency", lat, 52);
    chk("t5_data", {rsp_quot, rsp_rem, rsp_err}, 9'h1E1);
    chk("t5_start", div_start, 0);
    chk("t5_ack", div_ack, 0);
    pop("t5");
    never_done = 1'b0; m_rst = 1'b1;
    cyc(1);
    m_rst = 1'b0;
`endif

    chk("end_overlap_total", overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
